// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared opcodes, state encoding and helpers for muldiv_unit
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M/RV64M multiply/divide unit (shift-add / restoring divide)
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;

    state_t          state, next_state;
    logic [2:0]      op_q;
    logic            neg_res;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] opnd;
    logic [CW-1:0]   count;

    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] fast_result;

    logic [XLEN:0]   div_shift, add_a, add_b, add_sum;
    logic            sub;

    logic [2*XLEN-1:0] product, prod_fix;
    logic [XLEN-1:0]   div_sel, div_fix, fix_result;

    // Operand conditioning for launch; MUL is run unsigned since its low word is sign-invariant
    always_comb begin
        a_signed    = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed    = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg       = a_signed & a[XLEN-1];
        b_neg       = b_signed & b[XLEN-1];
        a_abs       = a_neg ? -a : a;
        b_abs       = b_neg ? -b : b;
        div_zero    = (b == '0);
        div_ovf     = b_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        fast        = is_div(op) && (div_zero || div_ovf);
        fast_result = op[1] ? (div_zero ? a : '0) : (div_zero ? '1 : a);
    end

    // One shared XLEN+1 adder: add for shift-add, subtract for restoring divide
    always_comb begin
        div_shift = {hi, lo[XLEN-1]};
        if (is_div(op_q)) begin
            add_a = div_shift;
            add_b = {1'b0, opnd};
            sub   = 1'b1;
        end else begin
            add_a = {1'b0, hi};
            add_b = lo[0] ? {1'b0, opnd} : '0;
            sub   = 1'b0;
        end
        add_sum = add_a + (add_b ^ {(XLEN+1){sub}}) + {{XLEN{1'b0}}, sub};
    end

    always_comb begin
        product    = {hi, lo};
        prod_fix   = neg_res ? -product : product;
        div_sel    = op_q[1] ? hi : lo;
        div_fix    = neg_res ? -div_sel : div_sel;
        if (is_div(op_q))
            fix_result = div_fix;
        else if (op_q == OP_MUL)
            fix_result = prod_fix[XLEN-1:0];
        else
            fix_result = prod_fix[2*XLEN-1:XLEN];
    end

    always_comb begin
        next_state = state;
        if (kill) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start && !fast) next_state = CALC;
                CALC:    if (count == CW'(1)) next_state = FIX;
                FIX:     next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            op_q    <= '0;
            neg_res <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            opnd    <= '0;
            count   <= '0;
        end else begin
            done <= 1'b0;
            busy <= (next_state != IDLE);
            if (!kill) begin
                case (state)
                    IDLE: if (start) begin
                        if (fast) begin
                            result <= fast_result;
                            done   <= 1'b1;
                        end else begin
                            op_q    <= op;
                            neg_res <= (is_div(op) && op[1]) ? a_neg : (a_neg ^ b_neg);
                            hi      <= '0;
                            lo      <= a_abs;
                            opnd    <= b_abs;
                            count   <= CW'(XLEN);
                        end
                    end
                    CALC: begin
                        count <= count - CW'(1);
                        if (!is_div(op_q)) begin
                            hi <= add_sum[XLEN:1];
                            lo <= {add_sum[0], lo[XLEN-1:1]};
                        end else if (!add_sum[XLEN]) begin
                            hi <= add_sum[XLEN-1:0];
                            lo <= {lo[XLEN-2:0], 1'b1};
                        end else begin
                            hi <= div_shift[XLEN-1:0];
                            lo <= {lo[XLEN-2:0], 1'b0};
                        end
                    end
                    FIX: begin
                        result <= fix_result;
                        done   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit (XLEN=32)
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] result;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] res;
    int          done_edge, busy_cnt, both_cnt, done_cnt;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .kill(kill), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch at the next edge (E0) and follow the op until done; done_edge is the edge index after E0
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output int de, output int bc, output int bd);
        int k;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0; bc = 0; bd = 0; de = -1;
        while (k < 100) begin
            if (busy && done) bd++;
            if (done) begin
                de = k;
                break;
            end
            if (busy) bc++;
            @(posedge clk); #1;
            k++;
        end
        r = result;
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done) n++;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(OP_MUL, 32'd7, 32'hFFFFFFFD, res, done_edge, busy_cnt, both_cnt);
        check("mul_result", res, 32'hFFFFFFEB);
        check("mul_done_edge", done_edge, 32'd33);
        check("mul_busy_cycles", busy_cnt, 32'd33);
        check("mul_busy_and_done", both_cnt, 32'd0);

        // Each following launch is driven in the done cycle of the previous op
        run_op(OP_MULH, 32'h80000000, 32'h80000000, res, done_edge, busy_cnt, both_cnt);
        check("mulh_result", res, 32'h40000000);
        check("b2b_done_edge", done_edge, 32'd33);
        run_op(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, res, done_edge, busy_cnt, both_cnt);
        check("mulhu_result", res, 32'hFFFFFFFE);
        run_op(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, res, done_edge, busy_cnt, both_cnt);
        check("mulhsu_result", res, 32'hFFFFFFFF);
        run_op(OP_MULH, 32'hFFFFFFF9, 32'd2, res, done_edge, busy_cnt, both_cnt);
        check("mulh_neg_result", res, 32'hFFFFFFFF);

        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, res, done_edge, busy_cnt, both_cnt);
        check("div_result", res, 32'hFFFFFFFD);
        check("div_done_edge", done_edge, 32'd33);
        run_op(OP_REM, 32'hFFFFFFF9, 32'd2, res, done_edge, busy_cnt, both_cnt);
        check("rem_result", res, 32'hFFFFFFFF);
        run_op(OP_DIVU, 32'd100, 32'd7, res, done_edge, busy_cnt, both_cnt);
        check("divu_result", res, 32'd14);
        run_op(OP_REMU, 32'd100, 32'd7, res, done_edge, busy_cnt, both_cnt);
        check("remu_result", res, 32'd2);
        run_op(OP_REM, 32'd100, 32'hFFFFFFF9, res, done_edge, busy_cnt, both_cnt);
        check("rem_pos_by_neg", res, 32'd2);

        run_op(OP_DIVU, 32'd5, 32'd0, res, done_edge, busy_cnt, both_cnt);
        check("divu_zero_result", res, 32'hFFFFFFFF);
        check("divu_zero_done_edge", done_edge, 32'd0);
        check("divu_zero_busy", busy_cnt, 32'd0);
        run_op(OP_REMU, 32'd5, 32'd0, res, done_edge, busy_cnt, both_cnt);
        check("remu_zero_result", res, 32'd5);
        check("remu_zero_done_edge", done_edge, 32'd0);
        check("remu_zero_busy", busy_cnt, 32'd0);
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, res, done_edge, busy_cnt, both_cnt);
        check("div_ovf_result", res, 32'h80000000);
        check("div_ovf_done_edge", done_edge, 32'd0);
        run_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, res, done_edge, busy_cnt, both_cnt);
        check("rem_ovf_result", res, 32'd0);
        @(posedge clk); #1;

        // Second start mid-CALC must be ignored
        op = OP_MUL; a = 32'd3; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_edge = -1;
        for (int k = 12; k < 100; k++) begin
            @(posedge clk); #1;
            if (done) begin
                done_edge = k;
                break;
            end
        end
        check("ignored_start_result", result, 32'd15);
        check("ignored_start_done_edge", done_edge, 32'd33);
        count_done(40, done_cnt);
        check("ignored_start_no_second_done", done_cnt, 32'd0);

        // Reset at CALC cycle 10
        op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("pre_reset_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("reset_mid_busy", {31'b0, busy}, 32'd0);
        check("reset_mid_result", result, 32'd0);
        check("reset_mid_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        count_done(40, done_cnt);
        check("reset_mid_no_done", done_cnt, 32'd0);

        // Kill at CALC cycle 10 keeps the prior result
        run_op(OP_DIVU, 32'd100, 32'd7, res, done_edge, busy_cnt, both_cnt);
        check("kill_setup_result", res, 32'd14);
        @(posedge clk); #1;
        op = OP_MUL; a = 32'd7; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_busy", {31'b0, busy}, 32'd0);
        check("kill_result_held", result, 32'd14);
        check("kill_done", {31'b0, done}, 32'd0);
        count_done(40, done_cnt);
        check("kill_no_done", done_cnt, 32'd0);

        // Kill in IDLE blocks a start, including a fast-path one
        op = OP_DIVU; a = 32'd5; b = 32'd0; start = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        check("kill_idle_busy", {31'b0, busy}, 32'd0);
        check("kill_idle_done", {31'b0, done}, 32'd0);
        check("kill_idle_result", result, 32'd14);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
